// File: rtl/sb_tx_arbiter.sv
// Sideband transmit scheduler: shares one 64-bit serializer between the SBINIT
// pattern generator and two message requesters, with an idle gap after each packet.
module sb_tx_arbiter #(
  parameter int GAP_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sb_abort,
  input  logic        i_pattern_valid,
  input  logic [63:0] i_pattern,
  input  logic        i_req0_valid,
  input  logic [63:0] i_req0_hdr,
  input  logic        i_req0_has_data,
  input  logic [63:0] i_req0_data,
  input  logic        i_req1_valid,
  input  logic [63:0] i_req1_hdr,
  input  logic        i_req1_has_data,
  input  logic [63:0] i_req1_data,
  input  logic        i_ser_done,
  output logic        o_ser_valid,
  output logic [63:0] o_ser_data,
  output logic        o_req0_ack,
  output logic        o_req1_ack,
  output logic        o_grant_id,
  output logic        o_busy
);

  localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {IDLE, PATTERN, HDR, DATA, GAP} state_t;

  state_t        state, state_nxt;
  logic          ser_valid_nxt;
  logic [63:0]   ser_data_nxt;
  logic          ack0_nxt, ack1_nxt;
  logic [CW-1:0] gap_cnt, gap_cnt_nxt;
  logic          rr_last, rr_last_nxt;
  logic [63:0]   cap_hdr, cap_hdr_nxt;
  logic [63:0]   cap_data, cap_data_nxt;
  logic          cap_has_data, cap_has_data_nxt;
  logic          cap_id, cap_id_nxt;
  logic          pick1;
  logic          finish;

  // On a tie, req1 wins only when req0 was the last one served.
  assign pick1      = i_req1_valid && (!i_req0_valid || !rr_last);
  assign o_grant_id = cap_id;

  always_comb begin
    state_nxt        = state;
    ser_valid_nxt    = 1'b0;
    ser_data_nxt     = '0;
    ack0_nxt         = 1'b0;
    ack1_nxt         = 1'b0;
    gap_cnt_nxt      = gap_cnt;
    rr_last_nxt      = rr_last;
    cap_hdr_nxt      = cap_hdr;
    cap_data_nxt     = cap_data;
    cap_has_data_nxt = cap_has_data;
    cap_id_nxt       = cap_id;
    finish           = 1'b0;

    case (state)
      IDLE: begin
        if (i_pattern_valid) begin
          state_nxt     = PATTERN;
          ser_valid_nxt = 1'b1;
          ser_data_nxt  = i_pattern;
        end else if (i_req0_valid || i_req1_valid) begin
          state_nxt        = HDR;
          cap_id_nxt       = pick1;
          cap_hdr_nxt      = pick1 ? i_req1_hdr : i_req0_hdr;
          cap_data_nxt     = pick1 ? i_req1_data : i_req0_data;
          cap_has_data_nxt = pick1 ? i_req1_has_data : i_req0_has_data;
          ser_valid_nxt    = 1'b1;
          ser_data_nxt     = pick1 ? i_req1_hdr : i_req0_hdr;
        end
      end
      PATTERN: begin
        ser_valid_nxt = 1'b1;
        ser_data_nxt  = o_ser_data;
        if (i_ser_done) begin
          if (i_pattern_valid) begin
            ser_data_nxt = i_pattern;
          end else begin
            state_nxt     = IDLE;
            ser_valid_nxt = 1'b0;
            ser_data_nxt  = '0;
          end
        end
      end
      HDR: begin
        ser_valid_nxt = 1'b1;
        ser_data_nxt  = cap_hdr;
        if (i_ser_done) begin
          if (cap_has_data) begin
            state_nxt    = DATA;
            ser_data_nxt = cap_data;
          end else begin
            finish = 1'b1;
          end
        end
      end
      DATA: begin
        ser_valid_nxt = 1'b1;
        ser_data_nxt  = cap_data;
        if (i_ser_done) finish = 1'b1;
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else gap_cnt_nxt = gap_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Packet fully serialized: acknowledge the owner and hand the serializer back.
    if (finish) begin
      ack0_nxt      = !cap_id;
      ack1_nxt      = cap_id;
      rr_last_nxt   = cap_id;
      ser_valid_nxt = 1'b0;
      ser_data_nxt  = '0;
      gap_cnt_nxt   = GAP_LOAD;
      state_nxt     = (GAP_CYCLES > 0) ? GAP : IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_sb_abort) begin
      state        <= IDLE;
      o_ser_valid  <= 1'b0;
      o_ser_data   <= '0;
      o_req0_ack   <= 1'b0;
      o_req1_ack   <= 1'b0;
      o_busy       <= 1'b0;
      gap_cnt      <= '0;
      rr_last      <= 1'b1;
      cap_hdr      <= '0;
      cap_data     <= '0;
      cap_has_data <= 1'b0;
      cap_id       <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_ser_valid  <= ser_valid_nxt;
      o_ser_data   <= ser_data_nxt;
      o_req0_ack   <= ack0_nxt;
      o_req1_ack   <= ack1_nxt;
      o_busy       <= (state_nxt != IDLE);
      gap_cnt      <= gap_cnt_nxt;
      rr_last      <= rr_last_nxt;
      cap_hdr      <= cap_hdr_nxt;
      cap_data     <= cap_data_nxt;
      cap_has_data <= cap_has_data_nxt;
      cap_id       <= cap_id_nxt;
    end
  end

endmodule

// File: doc/sb_tx_arbiter.md
# sb_tx_arbiter

Sideband transmit scheduler that shares the single 64-bit sideband serializer between the SBINIT clock-pattern generator and two message requesters (LTSM control messages and register-access/completion traffic). It sequences header and optional data phases, enforces a programmable inter-packet idle gap, and returns a completion acknowledge per packet. It sits between the packet framers/pattern generator and the sideband serializer, replacing the fixed pattern/packet mux selection with cycle-accurate ownership control.

## Interface
- GAP_CYCLES, 4, idle cycles inserted after every message packet (0–255; 0 = no gap)
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous reset, active low
- i_sb_abort  in  1  synchronous abort (LTSM returned to RESET); same effect as reset on state, outputs and RR pointer
- i_pattern_valid  in  1  pattern generator wants the serializer
- i_pattern  in  64  pattern phase
- i_req0_valid / i_req1_valid  in  1  message request (0 = LTSM, 1 = register path)
- i_req0_hdr / i_req1_hdr  in  64  framed header phase
- i_req0_has_data / i_req1_has_data  in  1  packet carries a 64-bit data phase
- i_req0_data / i_req1_data  in  64  framed data phase
- i_ser_done  in  1  serializer finished the current 64-bit phase (1-cycle pulse)
- o_ser_valid  out  1  o_ser_data is valid for the serializer
- o_ser_data  out  64  phase to serialize
- o_req0_ack / o_req1_ack  out  1  1-cycle pulse: packet fully serialized
- o_grant_id  out  1  requester owning the current packet
- o_busy  out  1  state is not IDLE

## Operation
- States: IDLE, PATTERN, HDR, DATA, GAP.
- IDLE: priority pattern > message requests. i_pattern_valid → PATTERN, load i_pattern. Else one or both requests → HDR; with both, grant the requester not granted last (RR pointer, resets to "last = 1", so req0 wins first tie). On grant, capture hdr, has_data, data and id into internal registers; requester inputs are not sampled again until IDLE.
- PATTERN: o_ser_valid=1. On i_ser_done: if i_pattern_valid still 1, reload i_pattern and stay; else → IDLE (no gap, no ack).
- HDR: o_ser_data = captured header. On i_ser_done: has_data → DATA (o_ser_data = captured data); else packet complete.
- DATA: on i_ser_done, packet complete.
- Packet complete: pulse ack of captured id, update RR pointer, → GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0).
- GAP: o_ser_valid=0, down-counter of width clog2(GAP_CYCLES+1) loaded with GAP_CYCLES-1 on entry; → IDLE when 0.
- Patterns preempt messages only at packet boundaries; a message in HDR/DATA always completes.
- i_ser_done while o_ser_valid=0 is ignored.
- Requester keeps valid high until it sees its ack; valid is not re-sampled in GAP, so no double grant.
- i_rst_n low or i_sb_abort high: → IDLE, all outputs 0, counter 0, RR pointer = 1; in-flight packet dropped without ack.

## Timing
- All outputs registered. Reset values: o_ser_valid 0, o_ser_data 0, acks 0, o_grant_id 0, o_busy 0.
- Request seen in IDLE at cycle N → o_ser_valid=1 with header at N+1.
- i_ser_done at M in HDR with data → data phase on o_ser_data at M+1, no bubble in o_ser_valid.
- Final i_ser_done at M → ack pulse and o_ser_valid=0 at M+1; GAP occupies M+1..M+GAP_CYCLES; IDLE at M+GAP_CYCLES+1; next header earliest at M+GAP_CYCLES+2.
- Pattern: i_ser_done at M with i_pattern_valid=1 → new i_pattern on o_ser_data at M+1, o_ser_valid stays 1.
- Abort and i_ser_done in same cycle: abort wins, no ack.

## Test plan
- Reset then req0 only, has_data=0, hdr=64'hA5A5_0000_0000_0001, done 3 cycles later → header at N+1, o_req0_ack one cycle after done, next grant no earlier than 6 cycles after done (GAP_CYCLES=4).
- req0 and req1 both valid from reset, each with data, held until ack → order req0, req1, req0, req1; each packet shows hdr then data back-to-back; exactly one ack per packet.
- i_pattern_valid and req1 both asserted in IDLE → PATTERN first; pattern reloaded on each done for 3 dones; drop i_pattern_valid → req1 header on cycle after IDLE, no gap after pattern.
- i_pattern_valid rises while req0 in DATA → req0 completes and acks, GAP runs, then PATTERN.
- i_sb_abort pulsed in DATA → next cycle all outputs 0, no ack; subsequent tie grants req0.
- GAP_CYCLES=0 build, req1 valid continuously, no data → back-to-back headers with exactly one idle (IDLE) cycle between done and next valid; spurious i_ser_done in IDLE has no effect.
